// File: rtl/regfile_dump_reader.sv
// regfile_dump_reader: walks a wrapping range of register-file indices and streams each value over valid/ready
module regfile_dump_reader #(
  parameter int NUM_REGS = 32,
  parameter int ADDR_W   = 5,
  parameter int DATA_W   = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] first_reg,
  input  logic [ADDR_W-1:0] last_reg,
  output logic [ADDR_W-1:0] rd_num,
  input  logic [DATA_W-1:0] rd_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_index,
  output logic              out_last,
  output logic              busy,
  output logic              done
);
  typedef enum logic [1:0] {IDLE, READ, HOLD, DONE} state_t;
  state_t            state_q, state_d;
  logic [ADDR_W-1:0] rd_num_q, rd_num_d, end_q, end_d, out_index_q, out_index_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              out_valid_q, out_valid_d, out_last_q, out_last_d;
  // rd_num_q doubles as the current index: it only moves when the next READ is about to use it
  always_comb begin
    state_d     = state_q;
    rd_num_d    = rd_num_q;
    end_d       = end_q;
    out_data_d  = out_data_q;
    out_index_d = out_index_q;
    out_last_d  = out_last_q;
    out_valid_d = out_valid_q;
    case (state_q)
      IDLE: if (start) begin
        state_d  = READ;
        rd_num_d = first_reg;
        end_d    = last_reg;
      end
      READ: begin
        state_d     = HOLD;
        out_data_d  = rd_data;
        out_index_d = rd_num_q;
        out_last_d  = rd_num_q == end_q;
        out_valid_d = 1'b1;
      end
      HOLD: if (out_ready) begin
        out_valid_d = 1'b0;
        state_d     = out_last_q ? DONE : READ;
        rd_num_d    = out_last_q ? rd_num_q : ADDR_W'((int'(rd_num_q) + 1) % NUM_REGS);
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      rd_num_q    <= '0;
      end_q       <= '0;
      out_data_q  <= '0;
      out_index_q <= '0;
      out_last_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      rd_num_q    <= rd_num_d;
      end_q       <= end_d;
      out_data_q  <= out_data_d;
      out_index_q <= out_index_d;
      out_last_q  <= out_last_d;
      out_valid_q <= out_valid_d;
    end
  end
  assign rd_num    = rd_num_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_index = out_index_q;
  assign out_last  = out_last_q;
  assign busy      = state_q != IDLE;
  assign done      = state_q == DONE;
endmodule

// File: tb/tb_regfile_dump_reader.sv
// tb_regfile_dump_reader: vector-table and scoreboard bench for the register dump reader
module tb_regfile_dump_reader;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [4:0]  first_reg = '0, last_reg = '0, rd_num, out_index;
  logic [31:0] rd_data, out_data;
  logic        out_valid, out_ready = 1'b1, out_last, busy, done;
  logic        we = 1'b0;
  logic [4:0]  wa = '0;
  logic [31:0] wd = '0;
  logic [31:0] rf [32];
  int          n_cmp = 0, n_bad = 0;

  typedef struct {
    logic [4:0] first, last;
    int         beats, stall_beat, wr_read_beat, ign_beat, rst_beat;
    bit         ign_done;
  } vec_t;
  typedef struct {
    logic [4:0]  idx;
    logic [31:0] data;
    logic        last;
  } beat_t;
  beat_t sb[$];
  vec_t  vecs[9];

  regfile_dump_reader dut (
    .clk(clk), .reset(reset), .start(start), .first_reg(first_reg), .last_reg(last_reg),
    .rd_num(rd_num), .rd_data(rd_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_index(out_index), .out_last(out_last), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;
  assign rd_data = rf[rd_num];
  // writes commit on the clock edge, like a real register-file write port
  always @(posedge clk) begin
    if (reset) for (int i = 0; i < 32; i++) rf[i] <= 32'hA000_0000 + i;
    else if (we) rf[wa] <= wd;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_range(input logic [4:0] first, input logic [4:0] last);
    logic [4:0] i = first;
    for (int k = 0; k < 32; k++) begin
      sb.push_back('{idx: i, data: rf[i], last: i == last});
      if (i == last) break;
      i = i + 5'd1;
    end
  endtask

  task automatic check_reset_outputs(input string name);
    check(name, 64'({rd_num, out_valid, out_data, out_index, out_last, busy, done}), 64'd0);
  endtask

  task automatic run(input vec_t v);
    int beats = 0, stall = 0, first_c = -1, last_c = -1, done_c = -1;
    bit aborted = 0;
    logic [37:0] held = '0;
    beat_t e;
    first_reg = v.first;
    last_reg  = v.last;
    start     = 1'b1;
    out_ready = 1'b1;
    push_range(v.first, v.last);
    tick;
    start = 1'b0;
    check("busy_after_start", 64'(busy), 64'd1);
    check("valid_in_read", 64'(out_valid), 64'd0);
    for (int c = 0; c < 200; c++) begin
      start = 1'b0;
      we    = 1'b0;
      if (done) begin
        done_c = c;
        break;
      end
      if (out_valid) begin
        if (first_c < 0) first_c = c;
        if (beats == v.rst_beat) begin
          reset = 1'b1;
          tick;
          reset = 1'b0;
          check_reset_outputs("reset_abort_outputs");
          aborted = 1;
          break;
        end
        if (beats == v.ign_beat && stall == 0) begin
          start     = 1'b1;
          first_reg = 5'd0;
          last_reg  = 5'd31;
        end
        if (beats == v.stall_beat && stall < 5) begin
          out_ready = 1'b0;
          if (stall == 0) begin
            held = {out_data, out_index, out_last};
            we   = 1'b1;
            wa   = out_index;
            wd   = ~out_data;
          end else check("stall_hold", 64'({out_valid, out_data, out_index, out_last}), 64'({1'b1, held}));
          stall++;
        end else begin
          out_ready = 1'b1;
          if (sb.size() == 0) check("unexpected_beat", 64'(out_index), 64'hFFFF);
          else begin
            e = sb.pop_front();
            check("beat_index", 64'(out_index), 64'(e.idx));
            check("beat_data", 64'(out_data), 64'(e.data));
            check("beat_last", 64'(out_last), 64'(e.last));
          end
          beats++;
          if (out_last) last_c = c;
        end
      end else if (busy && beats == v.wr_read_beat) begin
        we = 1'b1;
        wa = rd_num;
        wd = 32'h5555_0000 ^ 32'(rd_num);
      end
      tick;
    end
    we = 1'b0;
    check("beat_count", 64'(beats), 64'(v.beats));
    check("first_valid_latency", 64'(first_c), 64'd1);
    if (aborted) begin
      for (int k = 0; k < 4; k++) begin
        check("no_done_after_reset", 64'({done, out_valid, busy}), 64'd0);
        tick;
      end
      sb.delete();
      return;
    end
    if (done_c < 0) begin
      check("timeout_waiting_done", 64'd0, 64'd1);
      sb.delete();
      return;
    end
    check("done_after_last_hs", 64'(done_c), 64'(last_c + 1));
    check("scoreboard_drained", 64'(sb.size()), 64'd0);
    if (v.stall_beat < 0) check("throughput", 64'(done_c), 64'(2 * v.beats));
    if (v.ign_done) begin
      start     = 1'b1;
      first_reg = 5'd1;
      last_reg  = 5'd2;
    end
    tick;
    start = 1'b0;
    check("idle_after_done", 64'({busy, done, out_valid}), 64'd0);
    if (v.ign_done) begin
      tick;
      check("start_in_done_ignored", 64'({busy, out_valid}), 64'd0);
    end
    sb.delete();
  endtask

  initial begin
    //         first  last   beats stall wrrd ign  rst  ign_done
    vecs[0] = '{5'd3,  5'd5,  3,    -1,   -1,  -1,  -1,  0};
    vecs[1] = '{5'd30, 5'd1,  4,    -1,   -1,  -1,  -1,  0};
    vecs[2] = '{5'd7,  5'd6,  32,   -1,   -1,  -1,  -1,  0};
    vecs[3] = '{5'd8,  5'd8,  1,    -1,   -1,  -1,  -1,  0};
    vecs[4] = '{5'd12, 5'd15, 4,    1,    2,   -1,  -1,  0};
    vecs[5] = '{5'd20, 5'd22, 3,    -1,   -1,  1,   -1,  1};
    vecs[6] = '{5'd0,  5'd2,  3,    -1,   -1,  -1,  -1,  0};
    vecs[7] = '{5'd10, 5'd13, 1,    -1,   -1,  -1,  1,   0};
    vecs[8] = '{5'd5,  5'd9,  5,    -1,   -1,  -1,  -1,  0};
    tick;
    tick;
    check_reset_outputs("reset_state");
    reset = 1'b0;
    tick;
    check_reset_outputs("idle_without_start");
    out_ready = 1'b1;
    tick;
    check("ready_while_idle", 64'({out_valid, busy, done}), 64'd0);
    for (int n = 0; n < 9; n++) run(vecs[n]);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
